// File: rtl/seq_alu.sv
// Sequential add / multiply / popcount-dot / multiply-add unit behind valid/ready handshakes.
// Optional out_ovf port (high result half non-zero) is enabled by defining SEQ_ALU_OVF_EN.
module seq_alu #(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [1:0]       in_func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_result
`ifdef SEQ_ALU_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int H  = W / 2;
  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] F_ADD    = 2'b00;
  localparam logic [1:0] F_MUL    = 2'b01;
  localparam logic [1:0] F_DOT    = 2'b10;
  localparam logic [1:0] F_MULADD = 2'b11;

  if (W < 2 || (W % 2) != 0) begin : g_bad_width
    $error("seq_alu: W must be even and >= 2");
  end

  logic [1:0]     state_q, state_d;
  logic [1:0]     func_q, func_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] mc0_q, mc0_d, mc1_q, mc1_d;
  logic [W-1:0]   mp0_q, mp0_d, mp1_q, mp1_d;
  logic [2*W-1:0] acc0_q, acc0_d, acc1_q, acc1_d;
  logic [2*W-1:0] result_q, result_d;
`ifdef SEQ_ALU_OVF_EN
  logic           ovf_q, ovf_d;
`endif

  // Iteration source: live inputs on the accept edge, latched lanes while BUSY.
  logic [2*W-1:0] s_mc0, s_mc1, s_acc0, s_acc1;
  logic [W-1:0]   s_mp0, s_mp1;
  logic [1:0]     s_func;
  logic [CW-1:0]  s_cnt;
  logic [2*W-1:0] n_mc0, n_mc1, n_acc0, n_acc1, prod_sum, pop;
  logic [W-1:0]   n_mp0, n_mp1, ab;
  logic [CW-1:0]  n_cnt, last_cnt;
  logic           accept, is_final;

  assign in_ready   = (state_q == S_IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == S_DONE);
  assign out_result = result_q;
`ifdef SEQ_ALU_OVF_EN
  assign out_ovf    = ovf_q;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    s_mc0  = mc0_q;
    s_mc1  = mc1_q;
    s_mp0  = mp0_q;
    s_mp1  = mp1_q;
    s_acc0 = acc0_q;
    s_acc1 = acc1_q;
    s_func = func_q;
    s_cnt  = cnt_q;
    if (state_q == S_IDLE) begin
      s_acc0 = '0;
      s_acc1 = '0;
      s_func = in_func;
      s_cnt  = '0;
      if (in_func == F_MULADD) begin
        s_mc0 = (2*W)'(in_a[W-1:H]);
        s_mp0 = W'(in_a[H-1:0]);
        s_mc1 = (2*W)'(in_b[W-1:H]);
        s_mp1 = W'(in_b[H-1:0]);
      end else begin
        s_mc0 = (2*W)'(in_a);
        s_mp0 = in_b;
        s_mc1 = '0;
        s_mp1 = '0;
      end
    end

    n_acc0   = s_acc0 + (s_mp0[0] ? s_mc0 : '0);
    n_acc1   = s_acc1 + (s_mp1[0] ? s_mc1 : '0);
    n_mc0    = s_mc0 << 1;
    n_mc1    = s_mc1 << 1;
    n_mp0    = s_mp0 >> 1;
    n_mp1    = s_mp1 >> 1;
    n_cnt    = s_cnt + CW'(1);
    last_cnt = (s_func == F_MUL) ? CW'(W) : CW'(H);
    is_final = (n_cnt == last_cnt);
    prod_sum = n_acc0 + n_acc1;

    ab  = in_a & in_b;
    pop = '0;
    for (int i = 0; i < W; i++) pop = pop + (2*W)'(ab[i]);

    state_d  = state_q;
    func_d   = func_q;
    cnt_d    = cnt_q;
    mc0_d    = mc0_q;
    mc1_d    = mc1_q;
    mp0_d    = mp0_q;
    mp1_d    = mp1_q;
    acc0_d   = acc0_q;
    acc1_d   = acc1_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          func_d = in_func;
          if (in_func == F_ADD) begin
            result_d = (2*W)'(in_a) + (2*W)'(in_b);
            state_d  = S_DONE;
          end else if (in_func == F_DOT) begin
            result_d = pop;
            state_d  = S_DONE;
          end else if (is_final) begin
            result_d = prod_sum;
            state_d  = S_DONE;
          end else begin
            {mc0_d, mc1_d, mp0_d, mp1_d} = {n_mc0, n_mc1, n_mp0, n_mp1};
            {acc0_d, acc1_d}             = {n_acc0, n_acc1};
            cnt_d   = n_cnt;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        {mc0_d, mc1_d, mp0_d, mp1_d} = {n_mc0, n_mc1, n_mp0, n_mp1};
        {acc0_d, acc1_d}             = {n_acc0, n_acc1};
        cnt_d = n_cnt;
        if (is_final) begin
          result_d = prod_sum;
          cnt_d    = '0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        // Result reads as zero outside DONE, so it is cleared on handoff.
        if (out_ready) begin
          result_d = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef SEQ_ALU_OVF_EN
  assign ovf_d = |result_d[2*W-1:W];
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      func_q   <= F_ADD;
      cnt_q    <= '0;
      mc0_q    <= '0;
      mc1_q    <= '0;
      mp0_q    <= '0;
      mp1_q    <= '0;
      acc0_q   <= '0;
      acc1_q   <= '0;
      result_q <= '0;
`ifdef SEQ_ALU_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      cnt_q    <= cnt_d;
      mc0_q    <= mc0_d;
      mc1_q    <= mc1_d;
      mp0_q    <= mp0_d;
      mp1_q    <= mp1_d;
      acc0_q   <= acc0_d;
      acc1_q   <= acc1_d;
      result_q <= result_d;
`ifdef SEQ_ALU_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (W=4): directed vector table, reset/backpressure sequences, random ops vs model.
module tb_seq_alu;

  localparam int W = 4;

  localparam logic [1:0] F_ADD    = 2'b00;
  localparam logic [1:0] F_MUL    = 2'b01;
  localparam logic [1:0] F_DOT    = 2'b10;
  localparam logic [1:0] F_MULADD = 2'b11;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic [1:0]     in_func = 2'b00;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] out_result;
`ifdef SEQ_ALU_OVF_EN
  logic           out_ovf;
`endif

  int checks = 0;
  int errors = 0;

  seq_alu #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_func    (in_func),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
`ifdef SEQ_ALU_OVF_EN
    ,
    .out_ovf    (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]     func;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    int             hold;
    logic [2*W-1:0] exp_r;
    int             exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model straight from the arithmetic definitions.
  function automatic logic [2*W-1:0] model(input logic [1:0] f, input int a, input int b);
    int r, hw;
    hw = 1 << (W / 2);
    case (f)
      F_ADD: r = a + b;
      F_MUL: r = a * b;
      F_DOT: begin
        r = 0;
        for (int i = 0; i < W; i++) if (((a >> i) & 1) == 1 && ((b >> i) & 1) == 1) r++;
      end
      default: r = (a / hw) * (a % hw) + (b / hw) * (b % hw);
    endcase
    return (2*W)'(r);
  endfunction

  function automatic int model_lat(input logic [1:0] f);
    if (f == F_MUL) return W;
    if (f == F_MULADD) return W / 2;
    return 1;
  endfunction

  task automatic do_op(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, input logic [2*W-1:0] exp_r, input int exp_lat);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_func   = f;
    in_a      = a;
    in_b      = b;
    out_ready = (hold == 0);
    tick();
    lat = 1;
    // Inputs are don't-care after accept; a held in_valid must be ignored while busy.
    in_func = 2'($urandom);
    in_a    = W'($urandom);
    in_b    = W'($urandom);
    while (!out_valid && lat < 4 * W) begin
      check("in_ready_busy", 64'(in_ready), 64'd0);
      check("result_zero_busy", 64'(out_result), 64'd0);
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("out_valid", 64'(out_valid), 64'd1);
    check("result", 64'(out_result), 64'(exp_r));
`ifdef SEQ_ALU_OVF_EN
    check("ovf", 64'(out_ovf), 64'(exp_r >= (2*W)'(1 << W)));
`endif
    for (int k = 0; k < hold; k++) begin
      tick();
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_result", 64'(out_result), 64'(exp_r));
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("handoff_valid", 64'(out_valid), 64'd0);
    check("handoff_in_ready", 64'(in_ready), 64'd1);
    check("handoff_result", 64'(out_result), 64'd0);
  endtask

  initial begin
    vecs[0] = '{F_ADD,    4'b1111, 4'b0001, 0, 8'd16,  1};
    vecs[1] = '{F_MUL,    4'b1111, 4'b1111, 0, 8'd225, 4};
    vecs[2] = '{F_DOT,    4'b1011, 4'b1110, 0, 8'd2,   1};
    vecs[3] = '{F_MULADD, 4'b1111, 4'b1110, 0, 8'd15,  2};
    vecs[4] = '{F_MUL,    4'b0011, 4'b0101, 5, 8'd15,  4};
    vecs[5] = '{F_ADD,    4'b0000, 4'b0000, 0, 8'd0,   1};
    vecs[6] = '{F_MUL,    4'b0000, 4'b1111, 1, 8'd0,   4};
    vecs[7] = '{F_DOT,    4'b1111, 4'b1111, 0, 8'd4,   1};
    vecs[8] = '{F_MULADD, 4'b0110, 4'b1001, 2, 8'd4,   2};
    vecs[9] = '{F_MUL,    4'b1111, 4'b0001, 0, 8'd15,  4};

    rst = 1'b1;
    tick();
    tick();
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(out_result), 64'd0);
`ifdef SEQ_ALU_OVF_EN
    check("reset_ovf", 64'(out_ovf), 64'd0);
`endif
    rst = 1'b0;
    #1;
    check("release_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 10; i++)
      do_op(vecs[i].func, vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].exp_r, vecs[i].exp_lat);

    // Reset on the second BUSY cycle of a multiply aborts it.
    in_valid = 1'b1;
    in_func  = F_MUL;
    in_a     = 4'b1111;
    in_b     = 4'b1111;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("abort_in_ready_rst", 64'(in_ready), 64'd0);
    tick();
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_result", 64'(out_result), 64'd0);
    rst = 1'b0;
    #1;
    check("abort_release_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < W + 2; k++) begin
      tick();
      check("abort_no_emit", 64'(out_valid), 64'd0);
    end
    do_op(F_ADD, 4'b0010, 4'b0011, 0, 8'd5, 1);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]   f;
      logic [W-1:0] a, b;
      f = 2'($urandom_range(0, 3));
      a = W'($urandom);
      b = W'($urandom);
      do_op(f, a, b, $urandom_range(0, 2), model(f, int'(a), int'(b)), model_lat(f));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
